tap_mem_sched: RTL and testbench

TAP_MEM_SCHED -- requirements
Module: tap_mem_sched

---
 rtl/tap_mem_sched_pkg.sv | 22 ++
 rtl/tap_mem_sched_if.sv | 46 ++++
 rtl/tap_mem_sched_wr_arb.sv | 36 +++
 rtl/tap_mem_sched.sv | 118 +++++++++++
 tb/tb_tap_mem_sched.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tap_mem_sched_pkg.sv
// Shared types and sizing for the tap memory scheduler.
// Holds the default lane word width, lane count, row count and row address
// width, the requester indices used by the write arbiter, and the sweep FSM
// state encoding.
package tap_mem_sched_pkg;

  localparam int DW    = 32;  // lane word width
  localparam int LANES = 6;   // tap memory lanes
  localparam int DEPTH = 4;   // rows per lane
  localparam int AW    = 2;   // row address width

  // Bit positions in the write arbiter request/grant vectors
  localparam int REQ_HOST = 0;
  localparam int REQ_UPD  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/tap_mem_sched_if.sv
// Bus bundle for tap_mem_sched.
// slave  : scheduler side (sweep control in, write requests in, tap commands out)
// master : controller/test side (mirror of slave)
interface tap_mem_sched_if #(
  parameter int DW = tap_mem_sched_pkg::DW,
  parameter int AW = tap_mem_sched_pkg::AW
);
  logic          start;
  logic          busy;
  logic          pass_done;
  logic          upd_vld;
  logic [AW-1:0] upd_addr;
  logic          upd_rdy;
  logic          host_vld;
  logic [2:0]    host_lane;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          host_rdy;
  logic          tap_rd_vld;
  logic [AW-1:0] tap_rd_address;
  logic          tap_wr_vld;
  logic [AW-1:0] tap_wr_address;
  logic          tap_sub_vld;
  logic [2:0]    tap_sub_addr;
  logic [DW-1:0] tap_sub_data;
  logic          tap_inter;
  logic          tap_inter_first;
  logic          rd_data_vld;
  logic [AW-1:0] rd_data_addr;

  modport slave (
    input  start, upd_vld, upd_addr, host_vld, host_lane, host_addr, host_data,
    output busy, pass_done, upd_rdy, host_rdy,
           tap_rd_vld, tap_rd_address, tap_wr_vld, tap_wr_address,
           tap_sub_vld, tap_sub_addr, tap_sub_data, tap_inter, tap_inter_first,
           rd_data_vld, rd_data_addr
  );

  modport master (
    output start, upd_vld, upd_addr, host_vld, host_lane, host_addr, host_data,
    input  busy, pass_done, upd_rdy, host_rdy,
           tap_rd_vld, tap_rd_address, tap_wr_vld, tap_wr_address,
           tap_sub_vld, tap_sub_addr, tap_sub_data, tap_inter, tap_inter_first,
           rd_data_vld, rd_data_addr
  );
endinterface

// File: rtl/tap_mem_sched_wr_arb.sv
// tap_wr_arb: two-requester round-robin write arbiter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_req[1:0] : requests, bit REQ_HOST = host, bit REQ_UPD = update engine
//   o_gnt[1:0] : one-hot grant (combinational), all zero while in reset
// The last winner loses the next tie; out of reset the host wins ties.
module tap_wr_arb
  import tap_mem_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_host;  // 1: host won most recently, so update wins a tie

  always_comb begin
    o_gnt = 2'b00;
    if (!reset) begin
      if (i_req[REQ_HOST] && i_req[REQ_UPD]) begin
        o_gnt[REQ_HOST] = !r_last_host;
        o_gnt[REQ_UPD]  = r_last_host;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                r_last_host <= 1'b0;
    else if (o_gnt[REQ_HOST]) r_last_host <= 1'b1;
    else if (o_gnt[REQ_UPD])  r_last_host <= 1'b0;
  end

endmodule

// File: rtl/tap_mem_sched.sv
// tap_mem_sched: sweeps the tap memory rows with reads while arbitrating
// host single-lane writes against update-engine full-row writes.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : tap_mem_sched_if.slave -- start/busy/pass_done sweep control,
//                upd_* and host_* write requests with ready, tap_* memory
//                commands, rd_data_vld/rd_data_addr read-data strobe.
// A granted write to the row about to be read stalls the sweep one cycle so
// the read always returns post-write contents.
module tap_mem_sched #(
  parameter int DW    = tap_mem_sched_pkg::DW,
  parameter int LANES = tap_mem_sched_pkg::LANES,
  parameter int DEPTH = tap_mem_sched_pkg::DEPTH,
  parameter int AW    = tap_mem_sched_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  tap_mem_sched_if.slave  bus
);
  import tap_mem_sched_pkg::*;

  // The lane field is 3 bits wide; out-of-range lanes are decoded away by
  // the memory itself, so the scheduler only needs LANES to fit the field.
  if (LANES < 1 || LANES > 8) begin : g_lanes_chk
    $error("LANES must fit the 3-bit lane field");
  end

  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_rd_ptr, w_rd_ptr_nx;
  logic          r_rd_vld_p1;
  logic [AW-1:0] r_rd_addr_p1;

  logic [1:0]    w_req, w_gnt;
  logic          w_host_gnt, w_upd_gnt, w_wr_any;
  logic [AW-1:0] w_wr_addr;
  logic          w_stall, w_rd_issue;

  assign w_req[REQ_HOST] = bus.host_vld;
  assign w_req[REQ_UPD]  = bus.upd_vld;

  tap_wr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign w_host_gnt = w_gnt[REQ_HOST];
  assign w_upd_gnt  = w_gnt[REQ_UPD];
  assign w_wr_any   = w_host_gnt | w_upd_gnt;
  assign w_wr_addr  = w_host_gnt ? bus.host_addr :
                      w_upd_gnt  ? bus.upd_addr  : '0;

  assign w_stall    = (r_state == ST_SWEEP) && w_wr_any && (w_wr_addr == r_rd_ptr);
  assign w_rd_issue = (r_state == ST_SWEEP) && !w_stall && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rd_ptr     <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_rd_addr_p1 <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_rd_ptr     <= w_rd_ptr_nx;
      // p0 -> p1: read command to read data strobe
      r_rd_vld_p1  <= w_rd_issue;
      if (w_rd_issue) r_rd_addr_p1 <= r_rd_ptr;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_rd_ptr_nx = r_rd_ptr;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_rd_ptr_nx = '0;
          w_state_nx  = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (w_rd_issue) begin
          if (r_rd_ptr == LAST_ROW) begin
            w_rd_ptr_nx = '0;
            w_state_nx  = ST_DRAIN;
          end else begin
            w_rd_ptr_nx = r_rd_ptr + 1'b1;
          end
        end
      end
      ST_DRAIN: w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Registered outputs are masked during reset so every output reads 0.
  assign bus.busy            = !reset && (r_state != ST_IDLE);
  assign bus.pass_done       = !reset && (r_state == ST_DRAIN);
  assign bus.rd_data_vld     = !reset && r_rd_vld_p1;
  assign bus.rd_data_addr    = reset ? '0 : r_rd_addr_p1;

  assign bus.tap_rd_vld      = w_rd_issue;
  assign bus.tap_rd_address  = w_rd_issue ? r_rd_ptr : '0;
  assign bus.tap_inter       = w_rd_issue;
  assign bus.tap_inter_first = w_rd_issue && (r_rd_ptr == '0);

  assign bus.host_rdy        = w_host_gnt;
  assign bus.upd_rdy         = w_upd_gnt;
  assign bus.tap_wr_vld      = w_upd_gnt;
  assign bus.tap_wr_address  = w_wr_addr;
  assign bus.tap_sub_vld     = w_host_gnt;
  assign bus.tap_sub_addr    = w_host_gnt ? bus.host_lane : 3'd0;
  assign bus.tap_sub_data    = w_host_gnt ? bus.host_data : '0;

endmodule

// File: tb/tb_tap_mem_sched.sv
// Directed testbench for tap_mem_sched: reset behaviour, write arbitration,
// host/update grants, plain sweep, hazard stall and mid-sweep reset.
module tb_tap_mem_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tap_mem_sched_if bus();

  tap_mem_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.start     = 1'b0;
    bus.upd_vld   = 1'b0;
    bus.upd_addr  = '0;
    bus.host_vld  = 1'b0;
    bus.host_lane = '0;
    bus.host_addr = '0;
    bus.host_data = '0;
  endtask

  // Checks the sweep-side outputs for one cycle; rd_data_addr only when valid.
  task automatic cyc(input string tag, input logic busy, input logic pd,
                     input logic rv, input logic [1:0] ra, input logic first,
                     input logic dv, input logic [1:0] da);
    chk({tag, "_busy"},  64'(bus.busy),            64'(busy));
    chk({tag, "_pd"},    64'(bus.pass_done),       64'(pd));
    chk({tag, "_rdv"},   64'(bus.tap_rd_vld),      64'(rv));
    chk({tag, "_inter"}, 64'(bus.tap_inter),       64'(rv));
    chk({tag, "_first"}, 64'(bus.tap_inter_first), 64'(first));
    if (rv) chk({tag, "_rda"}, 64'(bus.tap_rd_address), 64'(ra));
    chk({tag, "_dv"},    64'(bus.rd_data_vld),     64'(dv));
    if (dv) chk({tag, "_da"}, 64'(bus.rd_data_addr), 64'(da));
  endtask

  // Uncontended sweep: start in cycle 0, reads 0..3 in cycles 1-4,
  // data strobes in cycles 2-5, pass_done in cycle 5, idle in cycle 6.
  task automatic run_sweep(input string tag);
    logic       e_busy [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic       e_pd   [7] = '{0, 0, 0, 0, 0, 1, 0};
    logic       e_rv   [7] = '{0, 1, 1, 1, 1, 0, 0};
    logic [1:0] e_ra   [7] = '{0, 0, 1, 2, 3, 0, 0};
    logic       e_fst  [7] = '{0, 1, 0, 0, 0, 0, 0};
    logic       e_dv   [7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [1:0] e_da   [7] = '{0, 0, 0, 1, 2, 3, 0};
    for (int n = 0; n < 7; n++) begin
      bus.start = (n == 0);
      #1;
      cyc($sformatf("%s_c%0d", tag, n), e_busy[n], e_pd[n], e_rv[n], e_ra[n],
          e_fst[n], e_dv[n], e_da[n]);
      tick();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    // Reset with every request raised: all outputs must stay 0
    idle_inputs();
    reset         = 1'b1;
    bus.start     = 1'b1;
    bus.host_vld  = 1'b1;
    bus.upd_vld   = 1'b1;
    bus.host_lane = 3'd5;
    bus.host_data = 32'h1234_5678;
    tick();
    tick();
    chk("rst_host_rdy", 64'(bus.host_rdy),    64'd0);
    chk("rst_upd_rdy",  64'(bus.upd_rdy),     64'd0);
    chk("rst_sub_vld",  64'(bus.tap_sub_vld), 64'd0);
    chk("rst_sub_data", 64'(bus.tap_sub_data), 64'd0);
    chk("rst_wr_vld",   64'(bus.tap_wr_vld),  64'd0);
    chk("rst_busy",     64'(bus.busy),        64'd0);
    chk("rst_rd_vld",   64'(bus.tap_rd_vld),  64'd0);
    chk("rst_pd",       64'(bus.pass_done),   64'd0);
    chk("rst_dv",       64'(bus.rd_data_vld), 64'd0);
    idle_inputs();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    // Tie for 4 cycles: host first after reset, then alternate
    bus.host_vld  = 1'b1;
    bus.upd_vld   = 1'b1;
    bus.host_addr = 2'd1;
    bus.upd_addr  = 2'd3;
    bus.host_lane = 3'd2;
    bus.host_data = 32'h0000_0011;
    for (int n = 0; n < 4; n++) begin
      logic h;
      h = (n % 2 == 0);
      #1;
      chk($sformatf("rr%0d_host_rdy", n), 64'(bus.host_rdy),      64'(h));
      chk($sformatf("rr%0d_upd_rdy", n),  64'(bus.upd_rdy),       64'(!h));
      chk($sformatf("rr%0d_sub_vld", n),  64'(bus.tap_sub_vld),   64'(h));
      chk($sformatf("rr%0d_wr_vld", n),   64'(bus.tap_wr_vld),    64'(!h));
      chk($sformatf("rr%0d_wr_addr", n),  64'(bus.tap_wr_address), h ? 64'd1 : 64'd3);
      tick();
    end
    idle_inputs();

    // Single host write in IDLE
    bus.host_vld  = 1'b1;
    bus.host_lane = 3'd3;
    bus.host_addr = 2'd2;
    bus.host_data = 32'hDEAD_BEEF;
    #1;
    chk("hw_host_rdy", 64'(bus.host_rdy),       64'd1);
    chk("hw_upd_rdy",  64'(bus.upd_rdy),        64'd0);
    chk("hw_sub_vld",  64'(bus.tap_sub_vld),    64'd1);
    chk("hw_sub_addr", 64'(bus.tap_sub_addr),   64'd3);
    chk("hw_sub_data", 64'(bus.tap_sub_data),   64'hDEAD_BEEF);
    chk("hw_wr_addr",  64'(bus.tap_wr_address), 64'd2);
    chk("hw_wr_vld",   64'(bus.tap_wr_vld),     64'd0);
    tick();
    idle_inputs();
    #1;
    chk("hw_end_host_rdy", 64'(bus.host_rdy),    64'd0);
    chk("hw_end_sub_vld",  64'(bus.tap_sub_vld), 64'd0);
    tick();

    // Out-of-range lane is still granted
    bus.host_vld  = 1'b1;
    bus.host_lane = 3'd7;
    bus.host_addr = 2'd0;
    bus.host_data = 32'h0000_00A5;
    #1;
    chk("lane7_host_rdy", 64'(bus.host_rdy),     64'd1);
    chk("lane7_sub_vld",  64'(bus.tap_sub_vld),  64'd1);
    chk("lane7_sub_addr", 64'(bus.tap_sub_addr), 64'd7);
    tick();
    idle_inputs();

    run_sweep("sw1");

    // Sweep with a colliding update write on row 1 in cycle 2
    bus.start = 1'b1;
    #1;
    cyc("hz_c0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.start = 1'b0;
    #1;
    cyc("hz_c1", 1, 0, 1, 0, 1, 0, 0);
    tick();
    bus.upd_vld  = 1'b1;
    bus.upd_addr = 2'd1;
    #1;
    cyc("hz_c2", 1, 0, 0, 0, 0, 1, 0);
    chk("hz_c2_upd_rdy", 64'(bus.upd_rdy),        64'd1);
    chk("hz_c2_wr_vld",  64'(bus.tap_wr_vld),     64'd1);
    chk("hz_c2_wr_addr", 64'(bus.tap_wr_address), 64'd1);
    tick();
    // Non-colliding write (row 3 while reading row 1) must not stall
    bus.upd_addr = 2'd3;
    #1;
    cyc("hz_c3", 1, 0, 1, 1, 0, 0, 0);
    chk("hz_c3_upd_rdy", 64'(bus.upd_rdy), 64'd1);
    tick();
    idle_inputs();
    #1;
    cyc("hz_c4", 1, 0, 1, 2, 0, 1, 1);
    tick();
    cyc("hz_c5", 1, 0, 1, 3, 0, 1, 2);
    tick();
    cyc("hz_c6", 1, 1, 0, 0, 0, 1, 3);
    tick();
    cyc("hz_c7", 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset in cycle 3 of a sweep aborts it
    bus.start = 1'b1;
    #1;
    tick();
    bus.start = 1'b0;
    #1;
    cyc("ab_c1", 1, 0, 1, 0, 1, 0, 0);
    tick();
    cyc("ab_c2", 1, 0, 1, 1, 0, 1, 0);
    tick();
    reset = 1'b1;
    #1;
    cyc("ab_c3", 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int n = 4; n < 7; n++) begin
      #1;
      cyc($sformatf("ab_c%0d", n), 0, 0, 0, 0, 0, 0, 0);
      tick();
    end

    run_sweep("sw2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
